// File: rtl/s3_trit_packer.sv
// s3_trit_packer: packs mod-3 coefficients five at a time into base-3 bytes
// (t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4) and streams them over valid/ready.
module s3_trit_packer #(
  parameter int NTRITS = 700
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       trit_valid,
  input  logic [1:0] trit,
  output logic       trit_ready,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] byte_out,
  output logic       byte_last,
  output logic       done,
  output logic       err
);

  localparam int CW = (NTRITS < 2) ? 1 : $clog2(NTRITS + 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT, DONE} state_t;

  state_t          state, state_nx;
  logic [7:0]      acc;
  logic [2:0]      pos;
  logic [CW-1:0]   trit_cnt;
  logic [7:0]      weight;
  logic [7:0]      term;
  logic [7:0]      acc_sum;
  logic            accept;
  logic            last_trit;
  logic            group_end;

  // Status outputs decode straight from the state register, so nothing
  // combinational reaches an output from an input.
  assign trit_ready = (state == ACC);
  assign byte_valid = (state == OUT);
  assign done       = (state == DONE);

  assign accept    = (state == ACC) && trit_valid;
  assign last_trit = (trit_cnt == CW'(NTRITS - 1));
  assign group_end = (pos == 3'd4) || last_trit;
  assign acc_sum   = acc + term;

  // Positional weight 3^pos from a constant table; value 2 is a left shift,
  // illegal value 3 contributes nothing.
  always_comb begin
    weight = 8'd1;
    case (pos)
      3'd0:    weight = 8'd1;
      3'd1:    weight = 8'd3;
      3'd2:    weight = 8'd9;
      3'd3:    weight = 8'd27;
      default: weight = 8'd81;
    endcase
    term = 8'd0;
    case (trit)
      2'd1:    term = weight;
      2'd2:    term = {weight[6:0], 1'b0};
      default: term = 8'd0;
    endcase
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = ACC;
      ACC:  if (accept && group_end) state_nx = OUT;
      OUT:  if (byte_ready) state_nx = byte_last ? DONE : ACC;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Accumulator, group position, frame counter, output byte and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= 8'd0;
      pos       <= 3'd0;
      trit_cnt  <= '0;
      byte_out  <= 8'd0;
      byte_last <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= 8'd0;
            pos       <= 3'd0;
            trit_cnt  <= '0;
            byte_last <= 1'b0;
            err       <= 1'b0;
          end
        end
        ACC: begin
          if (accept) begin
            trit_cnt <= trit_cnt + 1'b1;
            acc      <= acc_sum;
            if (trit == 2'd3) err <= 1'b1;
            if (group_end) begin
              // Short final group: missing high trits are simply zero.
              byte_out  <= acc_sum;
              byte_last <= last_trit;
            end else begin
              pos <= pos + 3'd1;
            end
          end
        end
        OUT: begin
          if (byte_ready) begin
            acc       <= 8'd0;
            pos       <= 3'd0;
            byte_last <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s3_trit_packer.sv
// Directed bench for s3_trit_packer: one full-size instance (700 trits) and
// one short-frame instance (7 trits) sharing clock and reset.
module tb_s3_trit_packer;

  logic       clk;
  logic       rst;
  int         checks;
  int         errors;

  // Instance A: NTRITS = 700
  logic       start_a, tv_a, tr_a, bv_a, br_a, bl_a, done_a, err_a;
  logic [1:0] trit_a;
  logic [7:0] bo_a;
  // Instance B: NTRITS = 7
  logic       start_b, tv_b, tr_b, bv_b, br_b, bl_b, done_b, err_b;
  logic [1:0] trit_b;
  logic [7:0] bo_b;

  s3_trit_packer #(.NTRITS(700)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .trit_valid(tv_a), .trit(trit_a),
    .trit_ready(tr_a), .byte_valid(bv_a), .byte_ready(br_a), .byte_out(bo_a),
    .byte_last(bl_a), .done(done_a), .err(err_a)
  );

  s3_trit_packer #(.NTRITS(7)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .trit_valid(tv_b), .trit(trit_b),
    .trit_ready(tr_b), .byte_valid(bv_b), .byte_ready(br_b), .byte_out(bo_b),
    .byte_last(bl_b), .done(done_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helper: return both instances to IDLE with quiet inputs.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    start_a = 0; tv_a = 0; trit_a = 0; br_a = 0;
    start_b = 0; tv_b = 0; trit_b = 0; br_b = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_a = 1'($urandom); tv_a = 1'($urandom); trit_a = 2'($urandom); br_a = 1'($urandom);
      start_b = 1'($urandom); tv_b = 1'($urandom); trit_b = 2'($urandom); br_b = 1'($urandom);
      #1;
      checks++;
      if ({tr_a, bv_a, bo_a, bl_a, done_a, err_a} !== 13'd0 ||
          {tr_b, bv_b, bo_b, bl_b, done_b, err_b} !== 13'd0) begin
        errors++;
        $display("FAIL reset_outputs: a=%b/%b/%0d/%b/%b/%b b=%b/%b/%0d/%b/%b/%b required all 0",
                 tr_a, bv_a, bo_a, bl_a, done_a, err_a, tr_b, bv_b, bo_b, bl_b, done_b, err_b);
      end
    end
    @(negedge clk);
    start_a = 0; start_b = 0;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tv_a = 1'($urandom); tv_b = 1'($urandom);
      checks++;
      if ({tr_a, bv_a, tr_b, bv_b} !== 4'b0) begin
        errors++;
        $display("FAIL idle_after_reset: ready/valid a=%b%b b=%b%b required 0000", tr_a, bv_a, tr_b, bv_b);
      end
    end
    tv_a = 0; tv_b = 0;
  endtask

  task automatic test_single_byte();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    start_a = 1; br_a = 1;
    @(negedge clk);
    start_a = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tr_a !== 1'b1) begin
        errors++;
        $display("FAIL single_ready_%0d: trit_ready=%b required 1", i, tr_a);
      end
      tv_a = 1; trit_a = seq[i];
      @(negedge clk);
    end
    tv_a = 0;
    checks++;
    if (bv_a !== 1'b1 || bo_a !== 8'd196 || bl_a !== 1'b0 || tr_a !== 1'b0) begin
      errors++;
      $display("FAIL single_byte: valid=%b byte=%0d last=%b ready=%b required 1/196/0/0",
               bv_a, bo_a, bl_a, tr_a);
    end
    do_reset();
  endtask

  task automatic test_full_frame();
    int nb = 0, thc = 0, cyc = 0, c1 = 0, c2 = 0, bad = 0;
    bit finished = 0;
    start_a = 1; br_a = 1;
    @(negedge clk);
    start_a = 0;
    while (cyc < 2000 && !finished) begin
      tv_a = 1; trit_a = 2'd2;
      if (tr_a) thc++;
      if (bv_a) begin
        nb++;
        if (nb == 1) c1 = cyc;
        if (nb == 2) c2 = cyc;
        if (bo_a !== 8'd242 || bl_a !== (nb == 140)) begin
          bad++;
          $display("FAIL full_byte_%0d: byte=%0d last=%b required 242/%b", nb, bo_a, bl_a, nb == 140);
        end
        if (bl_a) finished = 1;
      end
      @(negedge clk);
      cyc++;
    end
    tv_a = 0;
    checks++;
    if (!finished || nb != 140 || bad != 0) begin
      errors++;
      $display("FAIL full_frame_bytes: count=%0d bad=%0d required 140/0", nb, bad);
    end
    checks++;
    if (thc != 700) begin
      errors++;
      $display("FAIL full_frame_trits: handshakes=%0d required 700", thc);
    end
    checks++;
    if (c2 - c1 != 6) begin
      errors++;
      $display("FAIL full_throughput: byte spacing=%0d required 6", c2 - c1);
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL full_done: done=%b required 1", done_a);
    end
    @(negedge clk);
    checks++;
    if ({done_a, tr_a, bv_a} !== 3'b000) begin
      errors++;
      $display("FAIL full_idle: done/ready/valid=%b%b%b required 000", done_a, tr_a, bv_a);
    end
  endtask

  task automatic test_partial_frame();
    logic [1:0] seq [7] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
    logic [7:0] expb [2] = '{8'd121, 8'd5};
    int idx = 0, nb = 0, cyc = 0;
    bit finished = 0;
    start_b = 1; br_b = 1;
    @(negedge clk);
    start_b = 0;
    while (cyc < 200 && !finished) begin
      tv_b = 1; trit_b = (idx < 7) ? seq[idx] : 2'd0;
      if (tr_b) idx++;
      if (bv_b) begin
        checks++;
        if (nb > 1 || bo_b !== expb[nb] || bl_b !== (nb == 1)) begin
          errors++;
          $display("FAIL partial_byte_%0d: byte=%0d last=%b required %0d/%b",
                   nb, bo_b, bl_b, (nb > 1) ? 0 : expb[nb], nb == 1);
        end
        if (bl_b) finished = 1;
        nb++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!finished || done_b !== 1'b1) begin
      errors++;
      $display("FAIL partial_done: finished=%b done=%b required 1/1", finished, done_b);
    end
    for (int i = 0; i < 4; i++) begin
      if (tr_b) idx++;
      @(negedge clk);
    end
    tv_b = 0;
    checks++;
    if (idx != 7 || nb != 2) begin
      errors++;
      $display("FAIL partial_counts: trits=%0d bytes=%0d required 7/2", idx, nb);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] seq [10] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [7:0] expb [2] = '{8'd146, 8'd102};
    int idx = 0, nb = 0, stall = 0, cyc = 0;
    start_a = 1; br_a = 0;
    @(negedge clk);
    start_a = 0;
    while (cyc < 200 && nb < 2) begin
      tv_a = 1; trit_a = (idx < 10) ? seq[idx] : 2'd0;
      if (tr_a) idx++;
      br_a = 0;
      if (bv_a) begin
        if (nb == 0 && stall < 10) begin
          stall++;
          checks++;
          if (bo_a !== 8'd146 || tr_a !== 1'b0 || bl_a !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold_%0d: byte=%0d ready=%b last=%b required 146/0/0",
                     stall, bo_a, tr_a, bl_a);
          end
        end else begin
          br_a = 1;
          checks++;
          if (bo_a !== expb[nb]) begin
            errors++;
            $display("FAIL bp_byte_%0d: byte=%0d required %0d", nb, bo_a, expb[nb]);
          end
          nb++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    tv_a = 0; br_a = 0;
    checks++;
    if (nb != 2 || stall != 10 || idx != 10) begin
      errors++;
      $display("FAIL bp_counts: bytes=%0d stalls=%0d trits=%0d required 2/10/10", nb, stall, idx);
    end
    do_reset();
  endtask

  task automatic test_error();
    logic [1:0] seq [7] = '{2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [7:0] expb [2] = '{8'd3, 8'd0};
    int idx = 0, nb = 0, cyc = 0;
    bit finished = 0;
    start_b = 1; br_b = 1;
    @(negedge clk);
    start_b = 0;
    while (cyc < 200 && !finished) begin
      tv_b = 1; trit_b = (idx < 7) ? seq[idx] : 2'd0;
      if (tr_b) idx++;
      if (bv_b) begin
        checks++;
        if (nb > 1 || bo_b !== expb[nb] || err_b !== 1'b1) begin
          errors++;
          $display("FAIL err_byte_%0d: byte=%0d err=%b required %0d/1",
                   nb, bo_b, err_b, (nb > 1) ? 0 : expb[nb]);
        end
        if (bl_b) finished = 1;
        nb++;
      end
      @(negedge clk);
      cyc++;
    end
    tv_b = 0;
    @(negedge clk);
    checks++;
    if (!finished || tr_b !== 1'b0 || err_b !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky_idle: finished=%b ready=%b err=%b required 1/0/1", finished, tr_b, err_b);
    end
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    checks++;
    if (err_b !== 1'b0 || tr_b !== 1'b1) begin
      errors++;
      $display("FAIL err_clear_on_start: err=%b ready=%b required 0/1", err_b, tr_b);
    end
  endtask

  task automatic test_abort();
    logic [1:0] seq [3] = '{2'd3, 2'd2, 2'd2};
    start_a = 1; br_a = 1;
    @(negedge clk);
    start_a = 0;
    for (int i = 0; i < 3; i++) begin
      tv_a = 1; trit_a = seq[i];
      @(negedge clk);
    end
    checks++;
    if (err_a !== 1'b1 || tr_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: err=%b ready=%b required 1/1", err_a, tr_a);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({tr_a, bv_a, bo_a, bl_a, done_a, err_a} !== 13'd0) begin
      errors++;
      $display("FAIL abort_async: ready=%b valid=%b byte=%0d last=%b done=%b err=%b required all 0",
               tr_a, bv_a, bo_a, bl_a, done_a, err_a);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bv_a !== 1'b0 || tr_a !== 1'b0 || bo_a !== 8'd0) begin
        errors++;
        $display("FAIL abort_quiet_%0d: valid=%b ready=%b byte=%0d required 0/0/0", i, bv_a, tr_a, bo_a);
      end
    end
    tv_a = 0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    start_a = 0; tv_a = 0; trit_a = 0; br_a = 0;
    start_b = 0; tv_b = 0; trit_b = 0; br_b = 0;
    test_reset();
    test_single_byte();
    test_full_frame();
    test_partial_frame();
    test_backpressure();
    test_error();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/s3_trit_packer.md
# s3_trit_packer

Packs a stream of mod-3 coefficients (trits, 2 bits each) into bytes for the NTRU-HRSS serialiser. Sits directly downstream of the mod-3 reduction stage. It consumes one reduced trit per handshake and groups five consecutive trits into one byte, byte = t0 + 3·t1 + 9·t2 + 27·t3 + 81·t4, so every byte is in 0..242. It then emits the bytes over a valid/ready interface. One frame is one polynomial of NTRITS coefficients.

## Interface
Parameters:
- NTRITS, 700, trits per frame; must be ≥ 1. Frame length in bytes is NBYTES = ceil(NTRITS/5), which is 140 by default.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low. rst = 0 clears all state immediately.
- start  in  1  begins a frame; sampled only in IDLE.
- trit_valid  in  1  upstream trit is valid.
- trit  in  2  coefficient value. 0, 1 and 2 are legal; 3 is illegal.
- trit_ready  out  1  block accepts a trit this cycle.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  downstream accepts the byte.
- byte_out  out  8  packed byte.
- byte_last  out  1  marks the final byte of the frame; qualified by byte_valid.
- done  out  1  one-cycle pulse after the last byte handshake.
- err  out  1  sticky; set when an illegal trit is accepted.

## Operation
- The FSM has four states: IDLE, ACC, OUT, DONE.
- IDLE:
  - trit_ready = 0 and byte_valid = 0.
  - When start = 1: clear acc, pos, trit_cnt and err, then go to ACC.
- ACC:
  - trit_ready = 1.
  - A trit is accepted when trit_valid = 1 and trit_ready = 1. On accept:
    - acc ← acc + v·3^pos, where v = trit, except trit = 3 contributes 0 and sets err.
    - trit_cnt increments.
  - If pos = 4, or the accepted trit is number NTRITS of the frame (trit_cnt = NTRITS-1 before the increment): latch the new acc into byte_out and go to OUT.
  - Otherwise pos increments.
- OUT:
  - trit_ready = 0 and byte_valid = 1.
  - byte_last = 1 iff the frame's trits are exhausted.
  - On byte_ready = 1, clear acc and pos. Then go to DONE if byte_last = 1, otherwise back to ACC.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- Partial final group: when NTRITS mod 5 ≠ 0, the missing high trits count as 0. No padding trits are requested from upstream.
- Width rule: acc is 8 bits; its maximum is 242, so it never overflows. Weights 1, 3, 9, 27, 81 come from pos through a constant mux; no multiplier.
- err stays set until the next accepted start or reset.
- start outside IDLE is ignored.
- trit_valid outside ACC is not accepted. The upstream trit is held there by the handshake.

## Timing
- Reset values: trit_ready 0, byte_valid 0, byte_out 8'h00, byte_last 0, done 0, err 0, state IDLE.
- Registered outputs only; no combinational path from any input to any output.
- Start to ACC: start sampled in cycle k gives trit_ready = 1 in cycle k+1.
- Latency: the 5th trit accepted in cycle k gives byte_valid = 1 in cycle k+1.
- Throughput: with no stalls, one byte every 6 cycles (5 accept cycles plus 1 OUT cycle).
- Output hold: while byte_valid = 1 and byte_ready = 0, byte_out and byte_last hold stable. No trit is accepted during that stall.
- done rises the cycle after the last byte handshake. The next start can be sampled one cycle later, in IDLE.
- Reset mid-frame: rst going low aborts immediately. After release the block stays in IDLE with all outputs at their reset values; a partial byte is never emitted.

## Test plan
- Reset: hold rst = 0 with random inputs → all outputs 0. Release rst and keep start = 0 for 20 cycles → trit_ready and byte_valid stay 0.
- Single byte: start, then trits 1,2,0,1,2 with trit_valid always high → byte_out = 196 (1+6+0+27+162) one cycle after the 5th accept.
- Full frame, default NTRITS = 700, all trits = 2, byte_ready = 1:
  - 140 bytes, each 242.
  - byte_last only on byte 140.
  - done one cycle after that handshake, then the block returns to IDLE.
- Partial frame, NTRITS = 7, trits 1,1,1,1,1,2,1:
  - bytes 121 then 5 (2 + 3·1).
  - byte_last on the second byte; exactly 7 trit handshakes.
- Backpressure: byte_ready low for 10 cycles while byte_valid = 1 → byte_out stable and trit_ready = 0 throughout. Upstream trit_valid held high loses no trits.
- Error and abort:
  - Trits 3,1,0,0,0 → byte 3 and err = 1. err persists until the next start.
  - rst pulsed low after 3 trits of a new frame → immediate reset values. No byte is emitted after release.
